// File: rtl/dbg_arbiter.sv
// dbg_arbiter: two-port round-robin arbiter and command sequencer in front of dbg_module.
// Each accepted request is issued once, held until ready or timeout, and answered to its owner.
module dbg_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [7:0]  req0_cmd_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_data_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [7:0]  req1_cmd_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_data_i,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_data_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_data_o,
  output logic        rsp1_err_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        owner_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic last_q, owner, grant, win, multi, timed_out, done, done_err;
  logic [7:0] cmd_q;
  logic [31:0] addr_q, data_q, cnt, done_data;
  always_comb begin
    multi = cmd_q inside {8'h01, 8'h02, [8'h11:8'h16]};
    win = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
    grant = !rst_i && state == IDLE && dbg_ready_i && (req0_valid_i || req1_valid_i);
    timed_out = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES);
    done = (state == ISSUE && !multi) || (state == WAIT && (dbg_ready_i || timed_out));
    done_data = (state == WAIT && dbg_ready_i) ? dbg_data_i : 32'h0;
    done_err = done && state == WAIT && !dbg_ready_i;
  end
  assign req0_ready_o = grant && !win;
  assign req1_ready_o = grant && win;
  // Drop the command as soon as dbg_module signals ready so it is never re-issued.
  assign dbg_cmd_o = (state == ISSUE || (state == WAIT && !dbg_ready_i)) ? cmd_q : 8'h00;
  assign dbg_addr_o = addr_q;
  assign dbg_data_o = data_q;
  assign busy_o = state != IDLE;
  assign owner_o = owner;
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= IDLE;
      last_q <= 1'b1;
      owner <= 1'b0;
      cmd_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt <= '0;
      rsp0_valid_o <= 1'b0;
      rsp0_data_o <= '0;
      rsp0_err_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp1_data_o <= '0;
      rsp1_err_o <= 1'b0;
    end else begin
      rsp0_valid_o <= done && !owner;
      rsp0_data_o <= owner ? 32'h0 : done_data;
      rsp0_err_o <= done_err && !owner;
      rsp1_valid_o <= done && owner;
      rsp1_data_o <= owner ? done_data : 32'h0;
      rsp1_err_o <= done_err && owner;
      if (grant) begin
        state <= ISSUE;
        cmd_q <= win ? req1_cmd_i : req0_cmd_i;
        addr_q <= win ? req1_addr_i : req0_addr_i;
        data_q <= win ? req1_data_i : req0_data_i;
        owner <= win;
        last_q <= win;
      end else if (done) begin
        state <= IDLE;
      end else if (state == ISSUE) begin
        state <= WAIT;
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 32'd1;
      end
    end
  end
endmodule

// File: doc/dbg_arbiter.md
# dbg_arbiter

Two-port round-robin arbiter and command sequencer in front of `dbg_module`. It lets two hosts share the single debug command port, for example a UART debug bridge and a testbench/JTAG host. Each accepted request is replayed to `dbg_module` with the required stable-until-ready handshake. The arbiter removes the command on completion so it is never re-issued, and returns the result or a timeout error to the owning host.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum WAIT cycles before a command is aborted. 0 disables the timeout.

- `clk`  in  1  system clock
- `rst_i`  in  1  reset; synchronous, active-high
- `req0_valid_i` / `req1_valid_i`  in  1  request pending; cmd/addr/data held until accepted
- `req0_ready_o` / `req1_ready_o`  out  1  request accepted this cycle (valid & ready)
- `req0_cmd_i` / `req1_cmd_i`  in  8  debug command code
- `req0_addr_i` / `req1_addr_i`  in  32  address / register index
- `req0_data_i` / `req1_data_i`  in  32  write data
- `rsp0_valid_o` / `rsp1_valid_o`  out  1  one-cycle response pulse; no backpressure
- `rsp0_data_o` / `rsp1_data_o`  out  32  read data
- `rsp0_err_o` / `rsp1_err_o`  out  1  timeout flag, qualified by rsp valid
- `dbg_cmd_o`  out  8  to `dbg_module` `cmd_i`
- `dbg_addr_o`  out  32  to `addr_i`
- `dbg_data_o`  out  32  to `data_i`
- `dbg_data_i`  in  32  from `data_o`
- `dbg_ready_i`  in  1  from `ready_o`
- `busy_o`  out  1  state != IDLE
- `owner_o`  out  1  requester currently being served

## Operation
- **Command classes**
  - Multi-cycle: 0x01, 0x02, 0x11–0x16.
  - Single-cycle: every other code, including 0x00, 0x05–0x07 and undefined codes.
- **IDLE**
  - `dbg_cmd_o` = 0x00.
  - Grant only when `dbg_ready_i` = 1 and at least one valid is present.
  - Grant policy: if only one requester is valid, it wins. If both are valid, the requester != `last_q` wins.
  - Winner's `reqN_ready_o` = 1 (combinational). The arbiter latches cmd/addr/data and sets `owner_o`/`last_q` := winner, then moves to ISSUE.
- **ISSUE** (1 cycle)
  - `dbg_cmd_o` = latched cmd.
  - Single-cycle class: complete with data 0, err 0, then go to IDLE.
  - Multi-cycle class: go to WAIT and clear the timeout counter.
- **WAIT**
  - `dbg_cmd_o` = latched cmd, except while `dbg_ready_i` = 1, when it is 0x00. This gating is combinational so `dbg_module` never re-issues.
  - On `dbg_ready_i` = 1: complete with data = `dbg_data_i`, err 0, then go to IDLE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES` (nonzero), complete with data 0, err 1, then go to IDLE.
- **Completion**
  - Registers `rspN_valid_o` = 1 for one cycle, for N = owner, with data/err.
  - The other port's rsp outputs stay 0.
- **Address/data outputs**: `dbg_addr_o`/`dbg_data_o` always drive the latched values, which stay stable from ISSUE through WAIT.
- **After a timeout**: `dbg_module` recovers once `cmd_i` = 0x00. IDLE then waits for `dbg_ready_i` before the next grant.
- **Requester rules**: a requester may keep `valid` high across its own response. A new request is only accepted in IDLE.

## Timing
- **Accept cycle T** (IDLE), then:
  - T+1: ISSUE.
  - Single-cycle class: rsp at T+2, next accept possible at T+2.
  - Multi-cycle class: WAIT from T+2. If `dbg_ready_i` is first high at cycle W ≥ T+2, rsp is at W+1 and IDLE is at W+1.
  - Minimum multi-cycle latency is accept→rsp = 3 cycles, for a command that `dbg_module` finishes in the ISSUE cycle.
- **Timeout**: rsp err arrives exactly `TIMEOUT_CYCLES`+1 cycles after WAIT entry.
- **Reset** (`rst_i` high at a rising edge, including mid-ISSUE/WAIT):
  - State = IDLE, `last_q` = 1, counter 0, latches 0.
  - All outputs 0: `dbg_cmd_o`, `dbg_addr_o`, `dbg_data_o`, both ready, both rsp valid/data/err, `busy_o`, `owner_o`.
  - An in-flight command is dropped with no response.
- **Boundary conditions**:
  - After reset, simultaneous valids grant req0 first.
  - With both valids held continuously, grants alternate strictly.
  - While `dbg_ready_i` = 0 in IDLE, no grant is made and both ready outputs are 0.

## Test plan
- **Read, port 0**: req0 cmd 0x01 addr 0x100 accepted at T. Model drops ready at T+2 and raises it at T+6 with data 0xDEADBEEF. Required: `dbg_cmd_o` = 0x01 during T+1..T+5 and 0x00 at T+6; `rsp0_valid_o` at T+7 with data 0xDEADBEEF, err 0.
- **Fast write, port 1**: req1 cmd 0x02; `dbg_module` completes in ISSUE and ready never drops. Required: `dbg_cmd_o` = 0x02 only at T+1; `rsp1_valid_o` at T+3.
- **Arbitration**: just after reset, both valid (0x11 on req0, 0x12 on req1), held through several transactions. Required: grant order 0,1,0,1…, with `owner_o` and responses matching.
- **Single-cycle command**: req1 cmd 0x07. Required: `dbg_cmd_o` = 0x07 for exactly one cycle; `rsp1_valid_o` at T+2 with data 0, err 0.
- **Timeout**: `TIMEOUT_CYCLES` = 8, ready never returns. Required: rsp err 1 with data 0 at WAIT entry + 9; `dbg_cmd_o` 0x00 afterwards; no grant until `dbg_ready_i` = 1.
- **Reset mid-operation**: `rst_i` asserted during WAIT. Required: next cycle `dbg_cmd_o` 0, `busy_o` 0, no rsp pulse; the following simultaneous request grants req0.
